// File: rtl/alu_bit_serial_sequencer.sv
// alu_bit_serial_sequencer
// Drives an external one-bit ALU slice LSB-first to execute a WIDTH-bit
// ALU operation, chaining the slice carry-out back as the next carry-in.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_op, req_a, req_b        op code and operands
//   alu_ctrl, alu_a, alu_b,     slice drive: control word, operand bits,
//   alu_cin                     carry-in (all zero outside RUN)
//   alu_result, alu_cout        slice combinational outputs
//   resp_valid/resp_ready       response handshake
//   resp_result, resp_zero,     final result and flags
//   resp_overflow, resp_carry,
//   resp_err
//   busy                        high while the slice is being sequenced
module alu_bit_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_ctrl,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  input  logic             alu_result,
  input  logic             alu_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic             resp_carry,
  output logic             resp_err,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_PASSB = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [3:0]         op_q, op_d;
  logic               ovf_q, ovf_d;
  logic               fcarry_q, fcarry_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  // Op decode: slice control word, initial carry-in, supported flag
  logic [3:0] dec_ctrl;
  logic       dec_cin;
  logic       dec_ok;

  always_comb begin
    dec_ctrl = 4'b0000;
    dec_cin  = 1'b0;
    dec_ok   = 1'b1;
    case (req_op)
      OP_AND:   dec_ctrl = 4'b0000;
      OP_OR:    dec_ctrl = 4'b0001;
      OP_ADD:   dec_ctrl = 4'b0010;
      OP_SUB:   begin dec_ctrl = 4'b0110; dec_cin = 1'b1; end
      OP_SLT:   begin dec_ctrl = 4'b0110; dec_cin = 1'b1; end
      OP_NOR:   dec_ctrl = 4'b1100;
      OP_PASSB: dec_ctrl = 4'b0011;
      default:  dec_ok   = 1'b0;
    endcase
  end

  // Flag qualifiers from the captured op
  logic op_is_addsub;
  logic op_is_arith;
  logic op_is_slt;

  always_comb begin
    op_is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    op_is_slt    = (op_q == OP_SLT);
    op_is_arith  = op_is_addsub || op_is_slt;
  end

  // Slice drive and status outputs decoded straight from state flops
  always_comb begin
    req_ready     = rst_n && (state_q == ST_IDLE);
    busy          = (state_q == ST_RUN);
    resp_valid    = (state_q == ST_DONE);
    alu_ctrl      = busy ? ctrl_q    : 4'b0000;
    alu_a         = busy & a_sh_q[0];
    alu_b         = busy & b_sh_q[0];
    alu_cin       = busy & carry_q;
    resp_result   = res_q;
    resp_zero     = zero_q;
    resp_overflow = ovf_q;
    resp_carry    = fcarry_q;
    resp_err      = err_q;
  end

  // Next-state and datapath update
  logic             msb_ovf;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    carry_d   = carry_q;
    ctrl_d    = ctrl_q;
    op_d      = op_q;
    ovf_d     = ovf_q;
    fcarry_d  = fcarry_q;
    zero_d    = zero_q;
    err_d     = err_q;
    msb_ovf   = alu_cin ^ alu_cout;
    res_shift = {alu_result, res_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          a_sh_d   = req_a;
          b_sh_d   = req_b;
          op_d     = req_op;
          ctrl_d   = dec_ctrl;
          carry_d  = dec_cin;
          cnt_d    = '0;
          res_d    = '0;
          ovf_d    = 1'b0;
          fcarry_d = 1'b0;
          zero_d   = 1'b0;
          err_d    = 1'b0;
          if (dec_ok) begin
            state_d = ST_RUN;
          end else begin
            // Unsupported op completes immediately with an error response
            err_d   = 1'b1;
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        res_d   = res_shift;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = alu_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // MSB cycle: slice sum bit is the sign, cin^cout is signed overflow
          if (op_is_slt) begin
            res_d = WIDTH'(alu_result ^ msb_ovf);
          end
          ovf_d    = op_is_arith & msb_ovf;
          fcarry_d = op_is_addsub & alu_cout;
          zero_d   = (res_d == '0);
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ctrl_q   <= 4'b0000;
      op_q     <= 4'b0000;
      ovf_q    <= 1'b0;
      fcarry_q <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ctrl_q   <= ctrl_d;
      op_q     <= op_d;
      ovf_q    <= ovf_d;
      fcarry_q <= fcarry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_bit_serial_sequencer.sv
// Testbench for alu_bit_serial_sequencer with a behavioural one-bit ALU slice.
module tb_alu_bit_serial_sequencer;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       alu_ctrl;
  logic             alu_a;
  logic             alu_b;
  logic             alu_cin;
  logic             alu_result;
  logic             alu_cout;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_overflow;
  logic             resp_carry;
  logic             resp_err;
  logic             busy;

  alu_bit_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .alu_ctrl      (alu_ctrl),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_cin       (alu_cin),
    .alu_result    (alu_result),
    .alu_cout      (alu_cout),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_zero     (resp_zero),
    .resp_overflow (resp_overflow),
    .resp_carry    (resp_carry),
    .resp_err      (resp_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-bit ALU slice: optional input inversion, then AND/OR/ADD/pass-B
  logic sa, sb;
  always_comb begin
    sa         = alu_a ^ alu_ctrl[3];
    sb         = alu_b ^ alu_ctrl[2];
    alu_cout   = (sa & sb) | (sa & alu_cin) | (sb & alu_cin);
    alu_result = 1'b0;
    case (alu_ctrl[1:0])
      2'b00: alu_result = sa & sb;
      2'b01: alu_result = sa | sb;
      2'b10: alu_result = sa ^ sb ^ alu_cin;
      2'b11: alu_result = alu_b;
      default: alu_result = 1'b0;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        carry;
    logic        err;
    logic [3:0]  ctrl;
    logic        cin;
    int          lat;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  // Apply one request, follow it through RUN and DONE, check the response
  task automatic do_vec(input int idx, input vec_t v);
    int lat;
    bit seen;
    chk($sformatf("v%0d req_ready_idle", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 10 && !seen; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat++;
      if (resp_valid) begin
        seen = 1'b1;
      end else begin
        chk($sformatf("v%0d busy_run", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d ctrl_run", idx), 32'(alu_ctrl), 32'(v.ctrl));
        if (lat == 1) chk($sformatf("v%0d cin_first", idx), 32'(alu_cin), 32'(v.cin));
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d result", idx), resp_result, v.res);
    chk($sformatf("v%0d zero", idx), 32'(resp_zero), 32'(v.zero));
    chk($sformatf("v%0d overflow", idx), 32'(resp_overflow), 32'(v.ovf));
    chk($sformatf("v%0d carry", idx), 32'(resp_carry), 32'(v.carry));
    chk($sformatf("v%0d err", idx), 32'(resp_err), 32'(v.err));
    chk($sformatf("v%0d busy_done", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d ctrl_done", idx), 32'(alu_ctrl), 32'd0);
    chk($sformatf("v%0d ready_done", idx), 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk($sformatf("v%0d valid_drop", idx), 32'(resp_valid), 32'd0);
    chk($sformatf("v%0d ready_back", idx), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d result_hold", idx), resp_result, v.res);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    bit  stable;
    //            op       a             b             res           z     o     c     e     ctrl     cin  lat
    vecs[0]  = '{4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 33};
    vecs[1]  = '{4'b0001, 32'hF0000001, 32'h0000000E, 32'hF000000F, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 33};
    vecs[2]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 33};
    vecs[3]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 33};
    vecs[4]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b1, 33};
    vecs[5]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 33};
    vecs[6]  = '{4'b0111, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 33};
    vecs[7]  = '{4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 33};
    vecs[8]  = '{4'b1100, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 33};
    vecs[9]  = '{4'b0011, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 33};
    vecs[10] = '{4'b0101, 32'h12345678, 32'h87654321, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1};
    vecs[11] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 4'b0000;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst alu_bits", 32'({alu_a, alu_b, alu_cin}), 32'd0);
    chk("rst resp_result", resp_result, 32'd0);
    chk("rst resp_flags", 32'({resp_zero, resp_overflow, resp_carry, resp_err}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      do_vec(i, vecs[i]);
    end

    // Stall in DONE, ignored requests during RUN/DONE, no same-cycle re-accept
    req_valid = 1'b1;
    req_op    = 4'b0010;
    req_a     = 32'h7FFFFFFF;
    req_b     = 32'h00000001;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 10 && !seen; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat++;
      if (lat == 5) begin
        chk("run req_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_op    = 4'b0000;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'hFFFFFFFF;
      end
      if (resp_valid) seen = 1'b1;
    end
    chk("stall latency", 32'(lat), 32'd33);
    req_valid = 1'b1;
    req_op    = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      chk("stall ready_low", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("stall valid_hold", 32'(resp_valid), 32'd1);
      chk("stall result_hold", resp_result, 32'h80000000);
      chk("stall ovf_hold", 32'(resp_overflow), 32'd1);
    end
    // Request still raised while the response is accepted
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("handoff busy", 32'(busy), 32'd0);
    chk("handoff valid", 32'(resp_valid), 32'd0);
    chk("handoff ready", 32'(req_ready), 32'd1);
    stable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || resp_valid) stable = 1'b0;
    end
    chk("no queued request", 32'(stable), 32'd1);

    // Reset during RUN at bit 10 aborts the operation
    req_valid = 1'b1;
    req_op    = 4'b0110;
    req_a     = 32'h00000009;
    req_b     = 32'h00000003;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset busy", 32'(busy), 32'd1);
    chk("pre_reset ctrl", 32'(alu_ctrl), 32'h6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("midrst alu_bits", 32'({alu_a, alu_b, alu_cin}), 32'd0);
    chk("midrst resp_result", resp_result, 32'd0);
    chk("midrst resp_flags", 32'({resp_zero, resp_overflow, resp_carry, resp_err}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst ready_back", 32'(req_ready), 32'd1);
    stable = 1'b1;
    repeat (WIDTH + 8) begin
      @(posedge clk); #1;
      if (resp_valid || busy) stable = 1'b0;
    end
    chk("midrst no response", 32'(stable), 32'd1);

    // A fresh operation still works after the abort
    do_vec(100, vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
